// File: rtl/conditioner_pkg.sv
// conditioner_pkg: default parameter values shared by the multi-channel input
// conditioner and its testbench.
package conditioner_pkg;

   localparam int DEF_CHANNELS    = 4;  // independent input channels
   localparam int DEF_SYNC_STAGES = 2;  // synchroniser flop depth
   localparam int DEF_COUNT_WIDTH = 3;  // debounce counter width
   localparam int DEF_WAIT_TIME   = 3;  // cycles of disagreement before update

endpackage : conditioner_pkg

// File: rtl/conditioner_channel.sv
// conditioner_channel: one pin's worth of conditioning. It synchronises the
// raw pin, debounces it with a stable-time counter, and emits registered
// one-cycle edge pulses plus a sticky event flag with a level clear.
module conditioner_channel
   import conditioner_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int COUNT_WIDTH = DEF_COUNT_WIDTH,
   parameter int WAIT_TIME   = DEF_WAIT_TIME
) (
   input  logic clk,
   input  logic reset_n,
   input  logic noisysignal,
   input  logic enable,
   input  logic event_clear,
   output logic conditioned,
   output logic positiveedge,
   output logic negativeedge,
   output logic event_pending
);

   // Count value on which the next disagreeing cycle commits the new level.
   localparam logic [COUNT_WIDTH-1:0] LAST_COUNT = COUNT_WIDTH'(WAIT_TIME - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   synced;
   logic [COUNT_WIDTH-1:0] count_q;
   logic                   differs;
   logic                   expired;

   assign synced  = sync_q[SYNC_STAGES-1];
   assign differs = synced ^ conditioned;
   assign expired = differs && (count_q == LAST_COUNT);

   // Synchroniser chain: always running, independent of enable.
   // NOTE: non-blocking assignments make every stage sample its neighbour's
   // pre-edge value, so the chain shifts by exactly one stage per clock.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], noisysignal};
      end
   end

   // Debounce counter, debounced level and registered edge pulses.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         count_q      <= '0;
         conditioned  <= 1'b0;
         positiveedge <= 1'b0;
         negativeedge <= 1'b0;
      end else begin
         positiveedge <= 1'b0;
         negativeedge <= 1'b0;
         if (!enable || !differs) begin
            // Disabled, or one cycle of agreement: restart the stable-time count.
            count_q <= '0;
         end else if (expired) begin
            count_q      <= '0;
            conditioned  <= synced;
            positiveedge <= synced;
            negativeedge <= ~synced;
         end else begin
            count_q <= count_q + COUNT_WIDTH'(1);
         end
      end
   end

   // Sticky event flag: a pulse in the same cycle as a clear still sets it.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         event_pending <= 1'b0;
      end else begin
         event_pending <= positiveedge | negativeedge | (event_pending & ~event_clear);
      end
   end

endmodule : conditioner_channel

// File: rtl/inputconditioner_multi.sv
// inputconditioner_multi: CHANNELS independent pin conditioners sharing one
// clock and reset, plus a combined any-edge indication.
module inputconditioner_multi
   import conditioner_pkg::*;
#(
   parameter int CHANNELS    = DEF_CHANNELS,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int COUNT_WIDTH = DEF_COUNT_WIDTH,
   parameter int WAIT_TIME   = DEF_WAIT_TIME
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [CHANNELS-1:0] noisysignal,
   input  logic [CHANNELS-1:0] enable,
   input  logic [CHANNELS-1:0] event_clear,
   output logic [CHANNELS-1:0] conditioned,
   output logic [CHANNELS-1:0] positiveedge,
   output logic [CHANNELS-1:0] negativeedge,
   output logic [CHANNELS-1:0] event_pending,
   output logic                any_edge
);

   // Reject parameter sets the counter or chain cannot honour.
   if (CHANNELS < 1) begin : g_bad_channels
      $error("inputconditioner_multi: CHANNELS must be at least 1");
   end
   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("inputconditioner_multi: SYNC_STAGES must be at least 2");
   end
   if (WAIT_TIME < 1) begin : g_bad_wait_low
      $error("inputconditioner_multi: WAIT_TIME must be at least 1");
   end
   if (WAIT_TIME > (2 ** COUNT_WIDTH)) begin : g_bad_wait_high
      $error("inputconditioner_multi: WAIT_TIME exceeds 2**COUNT_WIDTH");
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      conditioner_channel #(
         .SYNC_STAGES (SYNC_STAGES),
         .COUNT_WIDTH (COUNT_WIDTH),
         .WAIT_TIME   (WAIT_TIME)
      ) u_channel (
         .clk           (clk),
         .reset_n       (reset_n),
         .noisysignal   (noisysignal[i]),
         .enable        (enable[i]),
         .event_clear   (event_clear[i]),
         .conditioned   (conditioned[i]),
         .positiveedge  (positiveedge[i]),
         .negativeedge  (negativeedge[i]),
         .event_pending (event_pending[i])
      );
   end

   // Pulses are registered, so this reduction is glitch-free.
   assign any_edge = |(positiveedge | negativeedge);

endmodule : inputconditioner_multi
